// File: rtl/i2so_bist_chk.sv
// i2so_bist_chk: saw-tooth BIST checker at the I2S receive end of the loopback.
// Tracks the generator's sequence (start, +inc, wrap past upper limit), locks
// after LOCK_CNT consecutive good words, and flags and counts mismatches while
// locked. After LOSS_CNT consecutive misses it goes back to hunting.
// Optional macro BIST_CHK_FIRST_ERR_EN: enables capture of the first
// mismatching word and its expected value. Without it those ports read 0.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rf_bist_chk_en           checker enable (level)
//   rf_bist_start_val/inc/up_limit  saw-tooth model configuration
//   rf_bist_cnt_clr          pulse, clears error/word counters (and capture)
//   bist_in_data/xfc         received word and its valid strobe
//   bist_chk_locked          high while locked
//   bist_chk_err             one-cycle mismatch pulse
//   bist_chk_err_cnt/word_cnt  saturating counters
//   bist_chk_first_err_data/exp  first-mismatch capture
module i2so_bist_chk #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned INC_W    = 8,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rf_bist_chk_en,
  input  logic [DATA_W-1:0] rf_bist_start_val,
  input  logic [INC_W-1:0]  rf_bist_inc,
  input  logic [DATA_W-1:0] rf_bist_up_limit,
  input  logic              rf_bist_cnt_clr,
  input  logic [DATA_W-1:0] bist_in_data,
  input  logic              bist_in_xfc,
  output logic              bist_chk_locked,
  output logic              bist_chk_err,
  output logic [CNT_W-1:0]  bist_chk_err_cnt,
  output logic [CNT_W-1:0]  bist_chk_word_cnt,
  output logic [DATA_W-1:0] bist_chk_first_err_data,
  output logic [DATA_W-1:0] bist_chk_first_err_exp
);

  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam int unsigned SW = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {IDLE, HUNT, VERIFY, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [MW-1:0]     match_q, match_d;
  logic [SW-1:0]     miss_q, miss_d;
  logic              err_d;
  logic              word_ev;
  logic              locked_q, err_q;
  logic [CNT_W-1:0]  err_cnt_q, word_cnt_q;
  logic [DATA_W-1:0] nxt_in, nxt_exp;

  // One saw-tooth step; unsigned limit compare, adder wraps modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] step(input logic [DATA_W-1:0] x,
                                             input logic [DATA_W-1:0] st,
                                             input logic [INC_W-1:0]  inc,
                                             input logic [DATA_W-1:0] lim);
    return (x >= lim) ? st : x + DATA_W'(inc);
  endfunction

  assign nxt_in  = step(bist_in_data, rf_bist_start_val, rf_bist_inc, rf_bist_up_limit);
  assign nxt_exp = step(exp_q, rf_bist_start_val, rf_bist_inc, rf_bist_up_limit);

  // State register and model datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      exp_q    <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      err_q    <= err_d;
      locked_q <= (state_d == LOCKED);
    end
  end

  // Next-state and model update.
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    word_ev = 1'b0;
    if (!rf_bist_chk_en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = HUNT;
        HUNT: begin
          if (bist_in_xfc && (bist_in_data == rf_bist_start_val)) begin
            exp_d   = nxt_in;
            match_d = MW'(1);
            state_d = (LOCK_CNT == 1) ? LOCKED : VERIFY;
          end
        end
        VERIFY: begin
          if (bist_in_xfc) begin
            if (bist_in_data == exp_q) begin
              exp_d   = nxt_exp;
              match_d = match_q + MW'(1);
              if (match_q == MW'(LOCK_CNT - 1)) state_d = LOCKED;
            end else begin
              state_d = HUNT;
            end
          end
        end
        LOCKED: begin
          if (bist_in_xfc) begin
            word_ev = 1'b1;
            // Model free-runs; a bad word never reseeds it.
            exp_d   = nxt_exp;
            if (bist_in_data == exp_q) begin
              miss_d = '0;
            end else begin
              err_d  = 1'b1;
              miss_d = miss_q + SW'(1);
              if (miss_q == SW'(LOSS_CNT - 1)) state_d = HUNT;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Miss run restarts on every entry to LOCKED.
    if (state_q != LOCKED) miss_d = '0;
  end

  // Saturating counters; a counted event beats a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      if (err_d)
        err_cnt_q <= rf_bist_cnt_clr ? CNT_W'(1)
                   : ((&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_W'(1));
      else if (rf_bist_cnt_clr)
        err_cnt_q <= '0;
      if (word_ev)
        word_cnt_q <= rf_bist_cnt_clr ? CNT_W'(1)
                    : ((&word_cnt_q) ? word_cnt_q : word_cnt_q + CNT_W'(1));
      else if (rf_bist_cnt_clr)
        word_cnt_q <= '0;
    end
  end

  assign bist_chk_locked   = locked_q;
  assign bist_chk_err      = err_q;
  assign bist_chk_err_cnt  = err_cnt_q;
  assign bist_chk_word_cnt = word_cnt_q;

`ifdef BIST_CHK_FIRST_ERR_EN
  logic              fe_seen_q;
  logic [DATA_W-1:0] fe_data_q, fe_exp_q;

  // First mismatch since reset/clear; a clear coinciding with a miss captures it.
  always_ff @(posedge clk) begin
    if (rst) begin
      fe_seen_q <= 1'b0;
      fe_data_q <= '0;
      fe_exp_q  <= '0;
    end else if (err_d && (rf_bist_cnt_clr || !fe_seen_q)) begin
      fe_seen_q <= 1'b1;
      fe_data_q <= bist_in_data;
      fe_exp_q  <= exp_q;
    end else if (rf_bist_cnt_clr) begin
      fe_seen_q <= 1'b0;
      fe_data_q <= '0;
      fe_exp_q  <= '0;
    end
  end

  assign bist_chk_first_err_data = fe_data_q;
  assign bist_chk_first_err_exp  = fe_exp_q;
`else
  assign bist_chk_first_err_data = '0;
  assign bist_chk_first_err_exp  = '0;
`endif

endmodule

// File: tb/tb_i2so_bist_chk.sv
// Self-checking bench for i2so_bist_chk: directed scenarios plus a randomized
// run, all compared against a word-level behavioural model. A second instance
// with 4-bit counters exercises counter saturation.
module tb_i2so_bist_chk;

`ifdef BIST_CHK_FIRST_ERR_EN
  localparam bit FE_EN = 1'b1;
`else
  localparam bit FE_EN = 1'b0;
`endif

  localparam int IDL = 0, HNT = 1, VER = 2, LCK = 3;
  localparam int LOCK_N = 4, LOSS_N = 2;
  localparam int MAX_M = 65535, MAX_S = 15;

  logic        clk = 1'b0;
  logic        rst, en, clr, xfc;
  logic [31:0] start_val, up_limit, din;
  logic [7:0]  inc;

  logic        locked, err, locked_s, err_s;
  logic [15:0] err_cnt, word_cnt;
  logic [3:0]  err_cnt_s, word_cnt_s;
  logic [31:0] fe_data, fe_exp, fe_data_s, fe_exp_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  i2so_bist_chk dut (
    .clk(clk), .rst(rst), .rf_bist_chk_en(en), .rf_bist_start_val(start_val),
    .rf_bist_inc(inc), .rf_bist_up_limit(up_limit), .rf_bist_cnt_clr(clr),
    .bist_in_data(din), .bist_in_xfc(xfc), .bist_chk_locked(locked),
    .bist_chk_err(err), .bist_chk_err_cnt(err_cnt), .bist_chk_word_cnt(word_cnt),
    .bist_chk_first_err_data(fe_data), .bist_chk_first_err_exp(fe_exp));

  i2so_bist_chk #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .rf_bist_chk_en(en), .rf_bist_start_val(start_val),
    .rf_bist_inc(inc), .rf_bist_up_limit(up_limit), .rf_bist_cnt_clr(clr),
    .bist_in_data(din), .bist_in_xfc(xfc), .bist_chk_locked(locked_s),
    .bist_chk_err(err_s), .bist_chk_err_cnt(err_cnt_s), .bist_chk_word_cnt(word_cnt_s),
    .bist_chk_first_err_data(fe_data_s), .bist_chk_first_err_exp(fe_exp_s));

  // Behavioural model state (per received word, plain integers).
  int          m_mode, m_match, m_miss, m_errc, m_wordc, m_errc_s, m_wordc_s;
  logic [31:0] m_exp, m_fe_data, m_fe_exp;
  logic        m_err, m_locked;
  bit          m_fe_seen;

  function automatic logic [31:0] nxt(input logic [31:0] x);
    if (x >= up_limit) return start_val;
    return x + 32'(inc);
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_edge();
    bit          ev_err, ev_word;
    logic [31:0] old_exp;
    ev_err  = 1'b0;
    ev_word = 1'b0;
    old_exp = m_exp;
    if (rst) begin
      m_mode = IDL; m_match = 0; m_miss = 0; m_exp = '0;
      m_errc = 0; m_wordc = 0; m_errc_s = 0; m_wordc_s = 0;
      m_err = 1'b0; m_locked = 1'b0;
      m_fe_seen = 1'b0; m_fe_data = '0; m_fe_exp = '0;
      return;
    end
    if (!en) m_mode = IDL;
    else if (m_mode == IDL) m_mode = HNT;
    else if (xfc) begin
      if (m_mode == HNT) begin
        if (din == start_val) begin
          m_exp = nxt(din); m_match = 1;
          if (m_match == LOCK_N) begin m_mode = LCK; m_miss = 0; end
          else m_mode = VER;
        end
      end else if (m_mode == VER) begin
        if (din == m_exp) begin
          m_exp = nxt(m_exp); m_match++;
          if (m_match == LOCK_N) begin m_mode = LCK; m_miss = 0; end
        end else m_mode = HNT;
      end else begin
        ev_word = 1'b1;
        m_exp = nxt(m_exp);
        if (din == old_exp) m_miss = 0;
        else begin
          ev_err = 1'b1; m_miss++;
          if (m_miss == LOSS_N) m_mode = HNT;
        end
      end
    end
    if (ev_err) begin
      m_errc = clr ? 1 : sat(m_errc, MAX_M);
      m_errc_s = clr ? 1 : sat(m_errc_s, MAX_S);
    end else if (clr) begin m_errc = 0; m_errc_s = 0; end
    if (ev_word) begin
      m_wordc = clr ? 1 : sat(m_wordc, MAX_M);
      m_wordc_s = clr ? 1 : sat(m_wordc_s, MAX_S);
    end else if (clr) begin m_wordc = 0; m_wordc_s = 0; end
    if (ev_err && (clr || !m_fe_seen)) begin
      m_fe_seen = 1'b1; m_fe_data = din; m_fe_exp = old_exp;
    end else if (clr) begin
      m_fe_seen = 1'b0; m_fe_data = '0; m_fe_exp = '0;
    end
    m_err = ev_err;
    m_locked = (m_mode == LCK);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    xfc = 1'b1; din = d;
    tick();
    xfc = 1'b0;
  endtask

  // Disable, reprogram, clear counters, re-enable; leaves the checker in HUNT.
  task automatic restart(input logic [31:0] st, input logic [7:0] in, input logic [31:0] lim);
    en = 1'b0; tick();
    start_val = st; inc = in; up_limit = lim; clr = 1'b1; tick();
    clr = 1'b0; en = 1'b1; tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    checks += 6;
    if (locked !== 1'b0)     begin failures++; $display("FAIL reset_locked got=%0b exp=0", locked); end
    if (err !== 1'b0)        begin failures++; $display("FAIL reset_err got=%0b exp=0", err); end
    if (err_cnt !== 16'd0)   begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    if (word_cnt !== 16'd0)  begin failures++; $display("FAIL reset_word_cnt got=%0d exp=0", word_cnt); end
    if (fe_data !== 32'd0)   begin failures++; $display("FAIL reset_fe_data got=%h exp=0", fe_data); end
    if (fe_exp !== 32'd0)    begin failures++; $display("FAIL reset_fe_exp got=%h exp=0", fe_exp); end
    rst = 1'b0; tick();
  endtask

  task automatic test_lock();
    int seq[8] = '{0, 1, 2, 3, 4, 5, 0, 1};
    int errs = 0;
    restart(32'd0, 8'd1, 32'd5);
    for (int i = 0; i < 8; i++) begin
      send(32'(seq[i]));
      if (err) errs++;
      if (i == 2) begin
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL lock_early got=%0b exp=0", locked); end
      end
      if (i == 3) begin
        checks++;
        if (locked !== 1'b1) begin failures++; $display("FAIL lock_rise got=%0b exp=1", locked); end
      end
    end
    checks += 3;
    if (errs != 0)          begin failures++; $display("FAIL lock_err_pulses got=%0d exp=0", errs); end
    if (err_cnt !== 16'd0)  begin failures++; $display("FAIL lock_err_cnt got=%0d exp=0", err_cnt); end
    if (word_cnt !== 16'd4) begin failures++; $display("FAIL lock_word_cnt got=%0d exp=4", word_cnt); end
  endtask

  task automatic test_single_err();
    restart(32'd10, 8'd3, 32'd20);
    send(10); send(13); send(16); send(19);
    send(22); send(10); send(13);
    send(99);
    checks += 3;
    if (err !== 1'b1)       begin failures++; $display("FAIL single_err_pulse got=%0b exp=1", err); end
    if (err_cnt !== 16'd1)  begin failures++; $display("FAIL single_err_cnt got=%0d exp=1", err_cnt); end
    if (locked !== 1'b1)    begin failures++; $display("FAIL single_err_lock got=%0b exp=1", locked); end
    send(19);
    checks += 3;
    if (err !== 1'b0)       begin failures++; $display("FAIL single_next_err got=%0b exp=0", err); end
    if (err_cnt !== 16'd1)  begin failures++; $display("FAIL single_next_cnt got=%0d exp=1", err_cnt); end
    if (word_cnt !== 16'd5) begin failures++; $display("FAIL single_word_cnt got=%0d exp=5", word_cnt); end
  endtask

  task automatic test_loss_relock();
    clr = 1'b1; tick(); clr = 1'b0;
    send(1);
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL loss_first_bad_lock got=%0b exp=1", locked); end
    send(2);
    checks += 2;
    if (err_cnt !== 16'd2) begin failures++; $display("FAIL loss_err_cnt got=%0d exp=2", err_cnt); end
    if (locked !== 1'b0)   begin failures++; $display("FAIL loss_unlock got=%0b exp=0", locked); end
    send(10); send(13); send(16);
    checks++;
    if (locked !== 1'b0) begin failures++; $display("FAIL relock_early got=%0b exp=0", locked); end
    send(19);
    checks += 2;
    if (locked !== 1'b1)   begin failures++; $display("FAIL relock got=%0b exp=1", locked); end
    if (err_cnt !== 16'd2) begin failures++; $display("FAIL relock_err_cnt got=%0d exp=2", err_cnt); end
  endtask

  task automatic test_overflow();
    int errs = 0;
    restart(32'hFFFF_FFFE, 8'd2, 32'hFFFF_FFFF);
    send(32'hFFFF_FFFE); send(0); send(2); send(4);
    send(6); if (err) errs++;
    send(8); if (err) errs++;
    checks += 4;
    if (locked !== 1'b1)    begin failures++; $display("FAIL ovf_lock got=%0b exp=1", locked); end
    if (errs != 0)          begin failures++; $display("FAIL ovf_err_pulses got=%0d exp=0", errs); end
    if (err_cnt !== 16'd0)  begin failures++; $display("FAIL ovf_err_cnt got=%0d exp=0", err_cnt); end
    if (word_cnt !== 16'd2) begin failures++; $display("FAIL ovf_word_cnt got=%0d exp=2", word_cnt); end
  endtask

  task automatic test_saturation();
    clr = 1'b1; tick(); clr = 1'b0;
    // Alternate bad/good so lock is held while errors accumulate.
    for (int i = 0; i < 40; i++) send((i % 2 == 0) ? ~m_exp : m_exp);
    checks += 5;
    if (err_cnt_s !== 4'hF)   begin failures++; $display("FAIL sat_err_cnt got=%0d exp=15", err_cnt_s); end
    if (word_cnt_s !== 4'hF)  begin failures++; $display("FAIL sat_word_cnt got=%0d exp=15", word_cnt_s); end
    if (err_cnt !== 16'd20)   begin failures++; $display("FAIL sat_wide_err_cnt got=%0d exp=20", err_cnt); end
    if (word_cnt !== 16'd40)  begin failures++; $display("FAIL sat_wide_word_cnt got=%0d exp=40", word_cnt); end
    if (locked !== 1'b1)      begin failures++; $display("FAIL sat_lock got=%0b exp=1", locked); end
    send(~m_exp);
    checks++;
    if (err_cnt_s !== 4'hF) begin failures++; $display("FAIL sat_hold got=%0d exp=15", err_cnt_s); end
    send(m_exp);
  endtask

  task automatic test_clr_coincide();
    clr = 1'b1; send(~m_exp); clr = 1'b0;
    checks += 3;
    if (err_cnt !== 16'd1)  begin failures++; $display("FAIL clr_coin_err_cnt got=%0d exp=1", err_cnt); end
    if (word_cnt !== 16'd1) begin failures++; $display("FAIL clr_coin_word_cnt got=%0d exp=1", word_cnt); end
    if (locked !== 1'b1)    begin failures++; $display("FAIL clr_coin_lock got=%0b exp=1", locked); end
    send(m_exp);
  endtask

  task automatic test_first_err();
    restart(32'd0, 8'd1, 32'd5);
    for (int i = 0; i < 9; i++) send(32'(i % 6));
    send(32'h7);
    send(32'h9);
    checks += 2;
    if (fe_data !== (FE_EN ? 32'h7 : 32'h0)) begin failures++; $display("FAIL first_err_data got=%h exp=%h", fe_data, FE_EN ? 32'h7 : 32'h0); end
    if (fe_exp !== (FE_EN ? 32'h3 : 32'h0))  begin failures++; $display("FAIL first_err_exp got=%h exp=%h", fe_exp, FE_EN ? 32'h3 : 32'h0); end
  endtask

  task automatic test_disable();
    restart(32'd0, 8'd1, 32'd5);
    send(0); send(1); send(2); send(3); send(4);
    en = 1'b0; send(32'd77);
    checks += 4;
    if (locked !== 1'b0)    begin failures++; $display("FAIL dis_locked got=%0b exp=0", locked); end
    if (err !== 1'b0)       begin failures++; $display("FAIL dis_err got=%0b exp=0", err); end
    if (err_cnt !== 16'd0)  begin failures++; $display("FAIL dis_err_cnt got=%0d exp=0", err_cnt); end
    if (word_cnt !== 16'd1) begin failures++; $display("FAIL dis_word_cnt got=%0d exp=1", word_cnt); end
    send(32'd5); send(32'd88);
    checks += 2;
    if (err_cnt !== 16'd0)  begin failures++; $display("FAIL dis_hold_err got=%0d exp=0", err_cnt); end
    if (word_cnt !== 16'd1) begin failures++; $display("FAIL dis_hold_word got=%0d exp=1", word_cnt); end
    en = 1'b1; tick();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 600; i++) begin
      if (i % 80 == 0) begin
        start_val = 32'($urandom_range(0, 7));
        inc       = 8'($urandom_range(0, 3));
        up_limit  = 32'($urandom_range(0, 15));
      end
      rst = (i == 300);
      en  = ($urandom_range(0, 99) < 96);
      clr = ($urandom_range(0, 99) < 4);
      xfc = ($urandom_range(0, 99) < 75);
      if ($urandom_range(0, 99) < 80) din = (m_mode == LCK || m_mode == VER) ? m_exp : start_val;
      else din = 32'($urandom_range(0, 15));
      tick();
      checks++;
      if (locked !== m_locked || err !== m_err || err_cnt !== 16'(m_errc) ||
          word_cnt !== 16'(m_wordc) || locked_s !== m_locked || err_s !== m_err ||
          err_cnt_s !== 4'(m_errc_s) || word_cnt_s !== 4'(m_wordc_s) ||
          fe_data !== (FE_EN ? m_fe_data : 32'h0) || fe_exp !== (FE_EN ? m_fe_exp : 32'h0)) begin
        failures++;
        if (bad++ < 10)
          $display("FAIL rand_cycle%0d got lk=%0b er=%0b ec=%0d wc=%0d ecs=%0d wcs=%0d fd=%h fe=%h exp lk=%0b er=%0b ec=%0d wc=%0d ecs=%0d wcs=%0d fd=%h fe=%h",
                   i, locked, err, err_cnt, word_cnt, err_cnt_s, word_cnt_s, fe_data, fe_exp,
                   m_locked, m_err, m_errc, m_wordc, m_errc_s, m_wordc_s,
                   FE_EN ? m_fe_data : 32'h0, FE_EN ? m_fe_exp : 32'h0);
      end
    end
    rst = 1'b0; xfc = 1'b0; clr = 1'b0; en = 1'b1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; xfc = 1'b0; din = '0;
    start_val = '0; inc = 8'd1; up_limit = 32'd5;
    test_reset();
    test_lock();
    test_single_err();
    test_loss_relock();
    test_overflow();
    test_saturation();
    test_clr_coincide();
    test_first_err();
    test_disable();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
